// File: rtl/final_image_write_ctrl_pkg.sv
// final_image_pkg: image geometry, bus widths and sequencer states for the final-image writer
package final_image_pkg;
   localparam int IMG_W      = 400;
   localparam int IMG_H      = 400;
   localparam int IMG_PIXELS = IMG_W * IMG_H;
   localparam int AW         = 18;
   localparam int DW         = 8;
   typedef enum logic [2:0] {IDLE, RUN, DRAIN, DUMP, DONE} fiw_state_t;
endpackage

// File: rtl/final_image_write_ctrl_if.sv
// final_image_write_ctrl_if: valid/ready pixel request bus for the two producer lanes
interface final_image_write_ctrl_if #(
   parameter int AW = final_image_pkg::AW,
   parameter int DW = final_image_pkg::DW
);
   logic          req0_valid, req0_ready;
   logic [AW-1:0] req0_addr;
   logic [DW-1:0] req0_data;
   logic          req1_valid, req1_ready;
   logic [AW-1:0] req1_addr;
   logic [DW-1:0] req1_data;
   modport master (
      output req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
      input  req0_ready, req1_ready
   );
   modport slave (
      input  req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
      output req0_ready, req1_ready
   );
endinterface

// File: rtl/final_image_write_ctrl_rr_arbiter2.sv
// rr_arbiter2: two-requester round-robin grant; the pointer moves only when a grant is issued
module rr_arbiter2 (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [1:0] valid,
   output logic [1:0] grant
);
   logic ptr;
   // a lone requester always wins; on contention the lane named by ptr wins
   always_comb begin
      grant[0] = en & valid[0] & (~valid[1] | ~ptr);
      grant[1] = en & valid[1] & (~valid[0] | ptr);
   end
   // after a grant the other lane becomes preferred
   always_ff @(posedge clk)
      if (rst) ptr <= 1'b0;
      else if (|grant) ptr <= grant[0];
endmodule

// File: rtl/final_image_write_ctrl.sv
// final_image_write_ctrl: arbitrates two pixel lanes onto the final-image write port and sequences frame flush
module final_image_write_ctrl #(
   parameter int IMG_W = final_image_pkg::IMG_W,
   parameter int IMG_H = final_image_pkg::IMG_H,
   parameter int AW    = final_image_pkg::AW,
   parameter int DW    = final_image_pkg::DW
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    start,
   final_image_write_ctrl_if.slave req,
   output logic                    WE,
   output logic [AW-1:0]           wA,
   output logic [DW-1:0]           WD,
   output logic                    busy,
   output logic                    done,
   output logic                    dump,
   output logic                    err_addr,
   output logic [AW-1:0]           pix_count
);
   import final_image_pkg::*;
   localparam logic [AW:0] PIX = (AW+1)'(IMG_W * IMG_H);
   fiw_state_t    state;
   logic [1:0]    grant;
   logic [AW-1:0] addr;
   logic [DW-1:0] data;
   logic          in_range;
   logic [AW:0]   cnt_inc;
   rr_arbiter2 u_arb (
      .clk   (CLK),
      .rst   (RST),
      .en    (state == RUN),
      .valid ({req.req1_valid, req.req0_valid}),
      .grant (grant)
   );
   // steer the granted lane onto the write path and classify its address
   always_comb begin
      req.req0_ready = grant[0];
      req.req1_ready = grant[1];
      addr           = grant[1] ? req.req1_addr : req.req0_addr;
      data           = grant[1] ? req.req1_data : req.req0_data;
      in_range       = {1'b0, addr} < PIX;
      cnt_inc        = {1'b0, pix_count} + {{AW{1'b0}}, 1'b1};
   end
   // frame sequencer with registered write port and status outputs
   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= IDLE;
         WE        <= 1'b0;
         wA        <= '0;
         WD        <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         dump      <= 1'b0;
         err_addr  <= 1'b0;
         pix_count <= '0;
      end else begin
         WE   <= 1'b0;
         dump <= 1'b0;
         case (state)
            IDLE, DONE: if (start) begin
               state     <= RUN;
               busy      <= 1'b1;
               done      <= 1'b0;
               err_addr  <= 1'b0;
               pix_count <= '0;
            end
            RUN: if (|grant) begin
               if (in_range) begin
                  WE <= 1'b1;
                  wA <= addr;
                  WD <= data;
                  if ({1'b0, pix_count} != PIX) pix_count <= cnt_inc[AW-1:0];
                  if (cnt_inc == PIX) state <= DRAIN;
               end else err_addr <= 1'b1;
            end
            DRAIN: begin
               state <= DUMP;
               busy  <= 1'b0;
               dump  <= 1'b1;
            end
            DUMP: begin
               state <= DONE;
               done  <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_final_image_write_ctrl.sv
// tb_final_image_write_ctrl: directed vectors against a full-size instance and a 4x4 instance
module tb_final_image_write_ctrl;
   logic CLK = 1'b0;
   logic RST, start, s_start;
   int   n_cmp = 0, n_err = 0;
   logic        f_we, f_busy, f_done, f_dump, f_err;
   logic [17:0] f_wa, f_pix;
   logic [7:0]  f_wd;
   logic        s_we, s_busy, s_done, s_dump, s_err;
   logic [17:0] s_wa, s_pix;
   logic [7:0]  s_wd;
   final_image_write_ctrl_if f ();
   final_image_write_ctrl_if s ();
   final_image_write_ctrl dut (
      .CLK(CLK), .RST(RST), .start(start), .req(f.slave),
      .WE(f_we), .wA(f_wa), .WD(f_wd), .busy(f_busy), .done(f_done),
      .dump(f_dump), .err_addr(f_err), .pix_count(f_pix)
   );
   final_image_write_ctrl #(.IMG_W(4), .IMG_H(4)) dut_s (
      .CLK(CLK), .RST(RST), .start(s_start), .req(s.slave),
      .WE(s_we), .wA(s_wa), .WD(s_wd), .busy(s_busy), .done(s_done),
      .dump(s_dump), .err_addr(s_err), .pix_count(s_pix)
   );
   always #5 CLK = ~CLK;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask
   initial begin
      int a0, a1;
      int exp_g [4] = '{0, 1, 0, 1};
      RST = 1'b1; start = 1'b0; s_start = 1'b0;
      f.req0_valid = 1'b0; f.req0_addr = '0; f.req0_data = '0;
      f.req1_valid = 1'b0; f.req1_addr = '0; f.req1_data = '0;
      s.req0_valid = 1'b0; s.req0_addr = '0; s.req0_data = '0;
      s.req1_valid = 1'b0; s.req1_addr = '0; s.req1_data = '0;
      tick(); tick();
      RST = 1'b0;
      check("rst_we", f_we, 0); check("rst_busy", f_busy, 0); check("rst_done", f_done, 0);
      check("rst_dump", f_dump, 0); check("rst_err", f_err, 0); check("rst_pix", f_pix, 0);
      check("rst_wa", f_wa, 0); check("rst_wd", f_wd, 0);
      // single lane-0 write
      start = 1'b1; tick(); start = 1'b0;
      check("t1_busy", f_busy, 1);
      f.req0_valid = 1'b1; f.req0_addr = 18'd5; f.req0_data = 8'hA1; #1;
      check("t1_rdy0", f.req0_ready, 1); check("t1_rdy1", f.req1_ready, 0);
      tick(); f.req0_valid = 1'b0;
      check("t1_we", f_we, 1); check("t1_wa", f_wa, 5); check("t1_wd", f_wd, 8'hA1); check("t1_pix", f_pix, 1);
      tick();
      check("t1_we_idle", f_we, 0);
      // lone lane-1 write moves the preference back to lane 0
      f.req1_valid = 1'b1; f.req1_addr = 18'd7; f.req1_data = 8'h77; #1;
      check("l1_rdy1", f.req1_ready, 1);
      tick(); f.req1_valid = 1'b0;
      check("l1_wa", f_wa, 7); check("l1_wd", f_wd, 8'h77); check("l1_pix", f_pix, 2);
      // contention: grants alternate 0,1,0,1
      a0 = 0; a1 = 0;
      f.req0_valid = 1'b1; f.req1_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         f.req0_addr = 18'(a0); f.req0_data = 8'(8'h10 + a0);
         f.req1_addr = 18'(100 + a1); f.req1_data = 8'(8'h20 + a1); #1;
         check($sformatf("t2_rdy0_%0d", i), f.req0_ready, 32'(exp_g[i] == 0));
         check($sformatf("t2_rdy1_%0d", i), f.req1_ready, 32'(exp_g[i] == 1));
         tick();
         check($sformatf("t2_we_%0d", i), f_we, 1);
         if (exp_g[i] == 0) begin
            check($sformatf("t2_wa_%0d", i), f_wa, 32'(a0)); check($sformatf("t2_wd_%0d", i), f_wd, 32'(8'h10 + a0)); a0++;
         end else begin
            check($sformatf("t2_wa_%0d", i), f_wa, 32'(100 + a1)); check($sformatf("t2_wd_%0d", i), f_wd, 32'(8'h20 + a1)); a1++;
         end
      end
      f.req0_valid = 1'b0; f.req1_valid = 1'b0;
      check("t2_pix", f_pix, 6);
      // out-of-range address: accepted, not written, sticky error
      f.req1_valid = 1'b1; f.req1_addr = 18'd160000; #1;
      check("t3_rdy1", f.req1_ready, 1);
      tick(); f.req1_valid = 1'b0;
      check("t3_we", f_we, 0); check("t3_err", f_err, 1); check("t3_pix", f_pix, 6);
      f.req0_valid = 1'b1; f.req0_addr = 18'd8; f.req0_data = 8'h88;
      tick(); f.req0_valid = 1'b0;
      check("t3_we_ok", f_we, 1); check("t3_err_sticky", f_err, 1); check("t3_pix2", f_pix, 7);
      // start while running is ignored
      start = 1'b1; tick(); start = 1'b0;
      check("t5_run_busy", f_busy, 1); check("t5_run_pix", f_pix, 7); check("t5_run_err", f_err, 1);
      // reset with a pending grant
      f.req0_valid = 1'b1; f.req0_addr = 18'd9; f.req1_valid = 1'b1; f.req1_addr = 18'd9; #1;
      check("t6_pending", 32'(f.req0_ready | f.req1_ready), 1);
      RST = 1'b1; tick();
      check("t6_we", f_we, 0); check("t6_busy", f_busy, 0); check("t6_pix", f_pix, 0);
      check("t6_err", f_err, 0); check("t6_dump", f_dump, 0); check("t6_wa", f_wa, 0); check("t6_wd", f_wd, 0);
      check("t6_rdy", 32'(f.req0_ready | f.req1_ready), 0);
      RST = 1'b0; f.req0_valid = 1'b0; f.req1_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         check("t6_after_we", f_we, 0); check("t6_after_dump", f_dump, 0); check("t6_after_busy", f_busy, 0);
      end
      // 4x4 frame end-to-end
      s_start = 1'b1; tick(); s_start = 1'b0;
      s.req1_valid = 1'b1; s.req1_addr = 18'd20;
      tick(); s.req1_valid = 1'b0;
      check("t4_oor_we", s_we, 0); check("t4_oor_err", s_err, 1);
      for (int i = 0; i < 16; i++) begin
         if (i % 2 == 0) begin
            s.req0_valid = 1'b1; s.req1_valid = 1'b0; s.req0_addr = 18'(i); s.req0_data = 8'(i * 3);
         end else begin
            s.req1_valid = 1'b1; s.req0_valid = 1'b0; s.req1_addr = 18'(i); s.req1_data = 8'(i * 3);
         end
         tick();
         check($sformatf("t4_we_%0d", i), s_we, 1); check($sformatf("t4_wa_%0d", i), s_wa, 32'(i));
         check($sformatf("t4_pix_%0d", i), s_pix, 32'(i + 1)); check($sformatf("t4_dump_%0d", i), s_dump, 0);
      end
      check("t4_drain_busy", s_busy, 1); check("t4_drain_wd", s_wd, 45);
      check("t4_drain_rdy", s.req1_ready, 0);
      s.req1_valid = 1'b0;
      tick();
      check("t4_dump", s_dump, 1); check("t4_dump_we", s_we, 0); check("t4_dump_busy", s_busy, 0); check("t4_dump_done", s_done, 0);
      tick();
      check("t4_done", s_done, 1); check("t4_done_dump", s_dump, 0); check("t4_done_pix", s_pix, 16);
      tick();
      check("t4_done_hold", s_done, 1); check("t4_dump_once", s_dump, 0);
      // restart from DONE clears frame status
      s_start = 1'b1; tick(); s_start = 1'b0;
      check("t5_pix", s_pix, 0); check("t5_err", s_err, 0); check("t5_done", s_done, 0); check("t5_busy", s_busy, 1);
      s.req0_valid = 1'b1; s.req0_addr = 18'd3; #1;
      check("t5_rdy", s.req0_ready, 1);
      s.req0_valid = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
